// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bus_arbiter
// Purpose  : Four-agent ownership sequencer for the shared 8-bit bus with
//            header check, beat counting and end-of-transaction ack.
// Options  : ARB_TIMEOUT_EN enables the GRANT-state watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module bus_arbiter #(
    parameter int MAX_BEATS      = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic [1:0] owner_id,
    output logic       busy,
    input  logic       bus_valid,
    input  logic [7:0] bus_data,
    output logic       ack,
    output logic       hdr_err,
    output logic       timeout_err
);
    localparam int                BEAT_W   = $clog2(MAX_BEATS + 1);
    localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(MAX_BEATS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        XFER    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic [1:0]        rr_ptr, rr_ptr_nxt;
    logic [BEAT_W-1:0] beat_cnt, beat_cnt_nxt;
    logic [3:0]        grant_nxt;
    logic [1:0]        owner_nxt;
    logic              busy_nxt, ack_nxt, hdr_err_nxt, timeout_nxt;
    logic              req_owner, wd_expire;
    logic [1:0]        seq1, seq2, winner;
    logic              win_found;
    logic              unused_bus_bits;

    function automatic logic [1:0] inc3(input logic [1:0] x);
        return (x >= 2'd2) ? 2'd0 : x + 2'd1;
    endfunction

    assign req_owner       = req[owner_id];
    assign unused_bus_bits = ^{bus_data[7:4], bus_data[1:0]};
    assign seq1            = inc3(rr_ptr);
    assign seq2            = inc3(seq1);

    // Control agent pre-empts the round-robin among the crypto cores.
    always_comb begin
        win_found = 1'b1;
        winner    = 2'd3;
        if (req[3])            winner = 2'd3;
        else if (req[rr_ptr])  winner = rr_ptr;
        else if (req[seq1])    winner = seq1;
        else if (req[seq2])    winner = seq2;
        else                   win_found = 1'b0;
    end

`ifdef ARB_TIMEOUT_EN
    localparam int              WD_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES);
    logic [WD_W-1:0] wd_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wd_cnt <= '0;
        else if (state != GRANT || state_nxt != GRANT)
            wd_cnt <= '0;
        else if (!bus_valid && wd_cnt != WD_MAX)
            wd_cnt <= wd_cnt + 1'b1;
    end

    assign wd_expire = (state == GRANT) && !bus_valid && (wd_cnt == WD_MAX - 1'b1);
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign wd_expire          = 1'b0;
`endif

    always_comb begin
        state_nxt    = state;
        grant_nxt    = grant;
        owner_nxt    = owner_id;
        busy_nxt     = busy;
        rr_ptr_nxt   = rr_ptr;
        beat_cnt_nxt = beat_cnt;
        ack_nxt      = 1'b0;
        hdr_err_nxt  = 1'b0;
        timeout_nxt  = 1'b0;
        case (state)
            IDLE: begin
                busy_nxt     = 1'b0;
                beat_cnt_nxt = '0;
                if (win_found) begin
                    state_nxt = GRANT;
                    grant_nxt = 4'b0001 << winner;
                    owner_nxt = winner;
                    busy_nxt  = 1'b1;
                end
            end
            GRANT: begin
                if (bus_valid) begin
                    if (bus_data[3:2] == owner_id) begin
                        beat_cnt_nxt = BEAT_W'(1);
                        state_nxt    = XFER;
                    end else begin
                        hdr_err_nxt = 1'b1;
                        state_nxt   = RELEASE;
                    end
                end else if (!req_owner) begin
                    state_nxt = RELEASE;
                end else if (wd_expire) begin
                    timeout_nxt = 1'b1;
                    state_nxt   = RELEASE;
                end
            end
            XFER: begin
                if (bus_valid) begin
                    if (beat_cnt != BEAT_MAX)
                        beat_cnt_nxt = beat_cnt + 1'b1;
                    if (beat_cnt_nxt == BEAT_MAX)
                        state_nxt = RELEASE;
                end else if (!req_owner) begin
                    state_nxt = RELEASE;
                end
            end
            RELEASE: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
                if (owner_id != 2'd3)
                    rr_ptr_nxt = inc3(owner_id);
            end
            default: state_nxt = IDLE;
        endcase
        // Entering RELEASE: drop the grant and broadcast ack in the same cycle.
        if (state != RELEASE && state_nxt == RELEASE) begin
            ack_nxt   = 1'b1;
            grant_nxt = 4'b0000;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            grant       <= 4'b0000;
            owner_id    <= 2'd0;
            busy        <= 1'b0;
            ack         <= 1'b0;
            hdr_err     <= 1'b0;
            timeout_err <= 1'b0;
            rr_ptr      <= 2'd0;
            beat_cnt    <= '0;
        end else begin
            state       <= state_nxt;
            grant       <= grant_nxt;
            owner_id    <= owner_nxt;
            busy        <= busy_nxt;
            ack         <= ack_nxt;
            hdr_err     <= hdr_err_nxt;
            timeout_err <= timeout_nxt;
            rr_ptr      <= rr_ptr_nxt;
            beat_cnt    <= beat_cnt_nxt;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_arbiter
// Purpose  : Self-checking bench for bus_arbiter; ack outcomes are scored
//            against a queue of expected {owner, hdr_err, timeout_err}.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b0000;
    logic       bus_valid = 1'b0;
    logic [7:0] bus_data = 8'h00;
    logic [3:0] grant;
    logic [1:0] owner_id;
    logic       busy, ack, hdr_err, timeout_err;

    typedef struct packed {
        logic [1:0] owner;
        logic       herr;
        logic       terr;
    } exp_t;

    exp_t exp_q[$];
    exp_t exp_cur;
    int   total = 0;
    int   bad = 0;
    int   ack_seen = 0;

    bus_arbiter #(.MAX_BEATS(16), .TIMEOUT_CYCLES(64)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .grant      (grant),
        .owner_id   (owner_id),
        .busy       (busy),
        .bus_valid  (bus_valid),
        .bus_data   (bus_data),
        .ack        (ack),
        .hdr_err    (hdr_err),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Every ack consumes one expected transaction outcome.
    always @(negedge clk) begin
        if (rst_n && ack) begin
            ack_seen++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL ack_unexpected: got ack owner=%0d hdr_err=%0b timeout_err=%0b, expected no ack",
                         owner_id, hdr_err, timeout_err);
            end else begin
                exp_cur = exp_q.pop_front();
                if ({owner_id, hdr_err, timeout_err} !== exp_cur) begin
                    bad++;
                    $display("FAIL ack_outcome: got owner=%0d hdr_err=%0b timeout_err=%0b, expected owner=%0d hdr_err=%0b timeout_err=%0b",
                             owner_id, hdr_err, timeout_err, exp_cur.owner, exp_cur.herr, exp_cur.terr);
                end
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        total++;
        if ({grant, owner_id, busy, ack, hdr_err, timeout_err} !== 10'd0) begin
            bad++;
            $display("FAIL reset_outputs: got %b, expected 0", {grant, owner_id, busy, ack, hdr_err, timeout_err});
        end
        rst_n = 1'b1;
        tick();
        bus_valid = 1'b1;
        bus_data  = 8'h04;
        repeat (3) tick();
        bus_valid = 1'b0;
        total++;
        if ({busy, grant, hdr_err, ack_seen} !== {1'b0, 4'b0000, 1'b0, 32'd0}) begin
            bad++;
            $display("FAIL stray_beat_idle: got busy=%0b grant=%b hdr_err=%0b acks=%0d, expected all 0",
                     busy, grant, hdr_err, ack_seen);
        end
    endtask

    task automatic test_single();
        int acks0;
        acks0 = ack_seen;
        req = 4'b0010;
        tick();
        total++;
        if ({grant, owner_id, busy} !== {4'b0010, 2'd1, 1'b1}) begin
            bad++;
            $display("FAIL single_grant: got grant=%b owner=%0d busy=%0b, expected 0010/1/1", grant, owner_id, busy);
        end
        exp_q.push_back('{owner: 2'd1, herr: 1'b0, terr: 1'b0});
        bus_valid = 1'b1;
        bus_data  = 8'h04;
        tick();
        for (int i = 0; i < 3; i++) begin
            bus_data = 8'hA0 + 8'(i);
            tick();
        end
        total++;
        if ({grant, ack} !== {4'b0010, 1'b0}) begin
            bad++;
            $display("FAIL single_xfer_hold: got grant=%b ack=%0b, expected 0010/0", grant, ack);
        end
        bus_valid = 1'b0;
        req = 4'b0000;
        tick();
        total++;
        if ({ack, grant, busy} !== {1'b1, 4'b0000, 1'b1}) begin
            bad++;
            $display("FAIL single_release: got ack=%0b grant=%b busy=%0b, expected 1/0000/1", ack, grant, busy);
        end
        tick();
        total++;
        if ({ack, busy, ack_seen - acks0} !== {1'b0, 1'b0, 32'd1}) begin
            bad++;
            $display("FAIL single_idle: got ack=%0b busy=%0b acks=%0d, expected 0/0/1", ack, busy, ack_seen - acks0);
        end
    endtask

    task automatic test_hdr_err();
        req = 4'b0100;
        tick();
        total++;
        if (grant !== 4'b0100) begin
            bad++;
            $display("FAIL hdr_grant: got grant=%b, expected 0100", grant);
        end
        exp_q.push_back('{owner: 2'd2, herr: 1'b1, terr: 1'b0});
        bus_valid = 1'b1;
        bus_data  = 8'h14;
        tick();
        total++;
        if ({hdr_err, ack, grant, busy} !== {1'b1, 1'b1, 4'b0000, 1'b1}) begin
            bad++;
            $display("FAIL hdr_release: got hdr_err=%0b ack=%0b grant=%b busy=%0b, expected 1/1/0000/1",
                     hdr_err, ack, grant, busy);
        end
        bus_valid = 1'b0;
        req = 4'b0000;
        tick();
        total++;
        if ({hdr_err, busy} !== 2'b00) begin
            bad++;
            $display("FAIL hdr_idle: got hdr_err=%0b busy=%0b, expected 0/0", hdr_err, busy);
        end
    endtask

    task automatic test_priority();
        req = 4'b1011;
        tick();
        total++;
        if (grant !== 4'b1000) begin
            bad++;
            $display("FAIL prio_ctrl_first: got grant=%b, expected 1000", grant);
        end
        exp_q.push_back('{owner: 2'd3, herr: 1'b0, terr: 1'b0});
        bus_valid = 1'b1;
        bus_data  = 8'h0C;
        tick();
        bus_data  = 8'h55;
        tick();
        bus_valid = 1'b0;
        req = 4'b0011;
        tick();
        tick();
        total++;
        if (grant !== 4'b0000) begin
            bad++;
            $display("FAIL prio_gap: got grant=%b, expected 0000", grant);
        end
        tick();
        total++;
        if (grant !== 4'b0001) begin
            bad++;
            $display("FAIL prio_rr_0: got grant=%b, expected 0001", grant);
        end
        exp_q.push_back('{owner: 2'd0, herr: 1'b0, terr: 1'b0});
        bus_valid = 1'b1;
        bus_data  = 8'h00;
        tick();
        bus_valid = 1'b0;
        req = 4'b0010;
        tick();
        tick();
        tick();
        total++;
        if (grant !== 4'b0010) begin
            bad++;
            $display("FAIL prio_rr_1: got grant=%b, expected 0010", grant);
        end
        exp_q.push_back('{owner: 2'd1, herr: 1'b0, terr: 1'b0});
        bus_valid = 1'b1;
        bus_data  = 8'h04;
        tick();
        bus_valid = 1'b0;
        req = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_max_beats();
        logic [3:0] exp_g;
        logic       exp_a;
        req = 4'b0001;
        tick();
        total++;
        if (grant !== 4'b0001) begin
            bad++;
            $display("FAIL max_grant: got grant=%b, expected 0001", grant);
        end
        exp_q.push_back('{owner: 2'd0, herr: 1'b0, terr: 1'b0});
        bus_valid = 1'b1;
        bus_data  = 8'h00;
        for (int i = 1; i <= 20; i++) begin
            tick();
            exp_a = (i == 16);
            exp_g = (i == 16 || i == 17) ? 4'b0000 : 4'b0001;
            if (i == 18)
                exp_q.push_back('{owner: 2'd0, herr: 1'b0, terr: 1'b0});
            total++;
            if ({grant, ack} !== {exp_g, exp_a}) begin
                bad++;
                $display("FAIL max_beat_%0d: got grant=%b ack=%0b, expected %b/%0b", i, grant, ack, exp_g, exp_a);
            end
        end
        bus_valid = 1'b0;
        req = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_timeout();
        int acks0;
        int n;
        req = 4'b0010;
        tick();
        total++;
        if (grant !== 4'b0010) begin
            bad++;
            $display("FAIL to_grant: got grant=%b, expected 0010", grant);
        end
        acks0 = ack_seen;
`ifdef ARB_TIMEOUT_EN
        exp_q.push_back('{owner: 2'd1, herr: 1'b0, terr: 1'b1});
        n = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            n++;
            if (ack) break;
        end
        total++;
        if ({n, timeout_err, ack} !== {32'd64, 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL to_expire: got cycles=%0d timeout_err=%0b ack=%0b, expected 64/1/1", n, timeout_err, ack);
        end
        req = 4'b0000;
        tick();
`else
        n = 0;
        repeat (200) begin
            tick();
            n++;
        end
        total++;
        if ({grant, busy, timeout_err, ack_seen - acks0} !== {4'b0010, 1'b1, 1'b0, 32'd0}) begin
            bad++;
            $display("FAIL to_wait_%0d: got grant=%b busy=%0b timeout_err=%0b acks=%0d, expected 0010/1/0/0",
                     n, grant, busy, timeout_err, ack_seen - acks0);
        end
        exp_q.push_back('{owner: 2'd1, herr: 1'b0, terr: 1'b0});
        req = 4'b0000;
        tick();
        tick();
`endif
    endtask

    task automatic test_reset_mid();
        int acks0;
        req = 4'b0001;
        tick();
        bus_valid = 1'b1;
        bus_data  = 8'h00;
        repeat (4) tick();
        acks0 = ack_seen;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({grant, owner_id, busy, ack, hdr_err, timeout_err} !== 10'd0) begin
            bad++;
            $display("FAIL rst_async: got %b, expected 0", {grant, owner_id, busy, ack, hdr_err, timeout_err});
        end
        bus_valid = 1'b0;
        req = 4'b0000;
        tick(); tick();
        rst_n = 1'b1;
        tick(); tick();
        total++;
        if (ack_seen - acks0 !== 0) begin
            bad++;
            $display("FAIL rst_no_ack: got acks=%0d, expected 0", ack_seen - acks0);
        end
        req = 4'b0111;
        tick();
        total++;
        if (grant !== 4'b0001) begin
            bad++;
            $display("FAIL rst_rr_ptr: got grant=%b, expected 0001", grant);
        end
        exp_q.push_back('{owner: 2'd0, herr: 1'b0, terr: 1'b0});
        bus_valid = 1'b1;
        bus_data  = 8'h00;
        tick();
        bus_valid = 1'b0;
        req = 4'b0000;
        tick();
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL sim_timeout: got no finish, expected finish before 500000");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_hdr_err();
        test_priority();
        test_max_beats();
        test_timeout();
        test_reset_mid();
        tick();
        total++;
        if (exp_q.size() !== 0) begin
            bad++;
            $display("FAIL pending_acks: got %0d outstanding, expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
